// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: nibble-serial add/subtract over W = 4*NIBBLES bits.
// One 4-bit slice is reused LSB-first, with the ripple carry held between steps.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold the last operation
// RUN   | one nibble processed per clock, index 0 .. NIBBLES-1
// DONE  | one-cycle done pulse; result and flags valid
module addsub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   m,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_m;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_done;
    logic             r_busy;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_sum;
    logic             w_ovf;

    // B is complemented per nibble; the initial carry = m supplies the +1 for subtract.
    assign w_a_nib = r_a[4*r_idx +: 4];
    assign w_b_nib = r_b[4*r_idx +: 4] ^ {4{r_m}};
    assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    assign w_ovf   = (r_a[W-1] == (r_b[W-1] ^ r_m)) && (w_sum[3] != r_a[W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_m         <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_m      <= m;
                        r_carry  <= m;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_result[4*r_idx +: 4] <= w_sum[3:0];
                    r_carry                <= w_sum[4];
                    r_idx                  <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_carry_out <= w_sum[4];
                        r_overflow  <= w_ovf;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl with NIBBLES=4 (16-bit operands).
// Expected results are queued when an operation is launched and popped at done.
module tb_addsub_seq_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    addsub_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m         (m),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-level reference: A + (B ^ {W{m}}) + m.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
        logic [W-1:0] be;
        logic [W:0]   s;
        exp_t         e;
        be    = ib ^ {W{im}};
        s     = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, im};
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ov  = (ia[W-1] == be[W-1]) && (s[W-1] != ia[W-1]);
        return e;
    endfunction

    // Launch one operation and wait (bounded) for done; lat counts ticks from start assertion.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                         output int lat, output int bc);
        a = ia; b = ib; m = im; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        bc  = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy === 1'b1) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m = 1'b0; a = '0; b = '0;
        tick();
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done got %b, want 00", {busy, done});
        end
        n_checks++;
        if ({result, carry_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h co=%b ov=%b, want all 0", result, carry_out, overflow);
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy got %b, want 0", busy);
        end
    endtask

    task automatic test_add();
        int   lat, bc;
        exp_t e;
        sb_q.push_back(exp_t'{16'h2201, 1'b0, 1'b0});
        do_op(16'h1234, 16'h0FCD, 1'b0, lat, bc);
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL add_latency: done after %0d cycles, want 5", lat);
        end
        n_checks++;
        if (bc + ((busy === 1'b1) ? 1 : 0) !== 5) begin
            n_fail++;
            $display("FAIL add_busy_len: busy for %0d cycles, want 5", bc + ((busy === 1'b1) ? 1 : 0));
        end
        e = sb_q.pop_front();
        n_checks++;
        if ({result, carry_out, overflow} !== e) begin
            n_fail++;
            $display("FAIL add_result: got %h co=%b ov=%b, want %h co=%b ov=%b",
                     result, carry_out, overflow, e.res, e.co, e.ov);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_after_done: busy/done got %b, want 00", {busy, done});
        end
        n_checks++;
        if (result !== 16'h2201) begin
            n_fail++;
            $display("FAIL add_hold: result got %h, want 2201", result);
        end
    endtask

    task automatic test_sub();
        int   lat, bc;
        exp_t e;
        sb_q.push_back(exp_t'{16'hFFFE, 1'b0, 1'b0});
        sb_q.push_back(exp_t'{16'h7FFF, 1'b1, 1'b1});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) do_op(16'h0005, 16'h0007, 1'b1, lat, bc);
            else        do_op(16'h8000, 16'h0001, 1'b1, lat, bc);
            e = sb_q.pop_front();
            n_checks++;
            if (lat >= 50 || {result, carry_out, overflow} !== e) begin
                n_fail++;
                $display("FAIL sub_%0d: got %h co=%b ov=%b (lat %0d), want %h co=%b ov=%b",
                         i, result, carry_out, overflow, lat, e.res, e.co, e.ov);
            end
            tick();
        end
    endtask

    task automatic test_add_boundaries();
        int   lat, bc;
        exp_t e;
        sb_q.push_back(exp_t'{16'h8000, 1'b0, 1'b1});
        sb_q.push_back(exp_t'{16'h0000, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) do_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
            else        do_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
            e = sb_q.pop_front();
            n_checks++;
            if (lat >= 50 || {result, carry_out, overflow} !== e) begin
                n_fail++;
                $display("FAIL add_bound_%0d: got %h co=%b ov=%b (lat %0d), want %h co=%b ov=%b",
                         i, result, carry_out, overflow, lat, e.res, e.co, e.ov);
            end
            tick();
        end
    endtask

    task automatic test_busy_reject();
        int          nd;
        logic [W+1:0] got;
        exp_t        e;
        sb_q.push_back(exp_t'{16'h0002, 1'b0, 1'b0});
        a = 16'h0001; b = 16'h0001; m = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; m = 1'b1;
        nd  = 0;
        got = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) begin a = 16'h1234; b = 16'h4321; end
            if (i == 1) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                got = {result, carry_out, overflow};
            end
        end
        n_checks++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL busy_reject_count: %0d done pulses, want 1", nd);
        end
        e = sb_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL busy_reject_result: got %h, want %h", got, e);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_reject_idle: busy got %b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int   nd, prev, t;
        exp_t e;
        for (int i = 0; i < 3; i++) sb_q.push_back(model(16'h0010, 16'h0001, 1'b0));
        a = 16'h0010; b = 16'h0001; m = 1'b0; start = 1'b1;
        nd = 0; prev = -1; t = 0;
        while (nd < 3 && t < 60) begin
            tick();
            t++;
            if (done === 1'b1) begin
                if (nd > 0) begin
                    n_checks++;
                    if (t - prev !== 6) begin
                        n_fail++;
                        $display("FAIL b2b_period: %0d cycles between done pulses, want 6", t - prev);
                    end
                end
                prev = t;
                nd++;
                e = sb_q.pop_front();
                n_checks++;
                if ({result, carry_out, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: got %h co=%b ov=%b, want %h", nd, result, carry_out, overflow, e.res);
                end
                tick();
                t++;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_after_done: busy got %b, want 0", busy);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (nd !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: %0d operations completed, want 3", nd);
        end
        tick();
        tick();
    endtask

    task automatic test_random();
        int           lat, bc;
        logic [W-1:0] ra, rb;
        logic         rm;
        exp_t         e;
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom_range(0, 1));
            sb_q.push_back(model(ra, rb, rm));
            do_op(ra, rb, rm, lat, bc);
            e = sb_q.pop_front();
            n_checks++;
            if (lat !== 5 || {result, carry_out, overflow} !== e) begin
                n_fail++;
                $display("FAIL random_%0d: %h %s %h got %h co=%b ov=%b lat %0d, want %h co=%b ov=%b lat 5",
                         i, ra, rm ? "-" : "+", rb, result, carry_out, overflow, lat, e.res, e.co, e.ov);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int   lat, bc, nd;
        exp_t e;
        sb_q.push_back(exp_t'{16'h0000, 1'b1, 1'b0});
        do_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (lat >= 50 || {result, carry_out, overflow} !== e) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got %h co=%b, want %h co=%b", result, carry_out, e.res, e.co);
        end
        tick();
        a = 16'h00FF; b = 16'h0001; m = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, result, carry_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: busy=%b done=%b result=%h co=%b ov=%b, want all 0",
                     busy, done, result, carry_out, overflow);
        end
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) nd++;
        end
        n_checks++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: %0d done pulses after abort, want 0", nd);
        end
        sb_q.push_back(exp_t'{16'h3333, 1'b0, 1'b0});
        do_op(16'h1111, 16'h2222, 1'b0, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (lat !== 5 || {result, carry_out, overflow} !== e) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got %h co=%b ov=%b lat %0d, want %h lat 5",
                     result, carry_out, overflow, lat, e.res);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_add_boundaries();
        test_busy_reject();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
Nibble-serial add/subtract sequencer for wide operands. It reuses a single 4-bit add/sub slice: XOR-complement of B by mode bit m, plus carry-in. It steps that slice LSB-nibble-first over NIBBLES cycles and carries the ripple between steps. It sits between the operand registers and the result/flag consumers, and gives the team wide add/sub without instantiating wide adders.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request an operation; sampled only in IDLE
m  input  1  mode: 0 = A+B, 1 = A-B (B complemented, carry-in = 1)
a  input  W  operand A, sampled with start
b  input  W  operand B, sampled with start
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse: result and flags valid
result  output  W  sum/difference
carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE. It also clears nibble index, internal carry, latched operands, result, carry_out, overflow, done and busy to 0. Reset takes priority over everything.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b and m, sets carry=m, idx=0, result=0, and moves to RUN.
  - start=0 keeps the block in IDLE.
  - carry_out and overflow hold their previous values in IDLE.
- RUN: each edge computes s[4:0] = A[idx] + (B[idx] XOR {4{m}}) + carry, with 5-bit zero-extended arithmetic.
  - Writes s[3:0] into result nibble idx.
  - Sets carry <= s[4].
  - Increments idx.
  - When idx = NIBBLES-1 is processed, also loads carry_out <= s[4] and overflow <= (A[W-1] == Beff[W-1]) && (s[3] != A[W-1]), where Beff = B XOR {W{m}}, then goes to DONE.
- DONE: done=1 for exactly this one cycle, then unconditional return to IDLE at the next edge.
- Latency: start sampled at edge E0; nibbles are processed at edges E1..EN. done is high in the cycle between E(N) and E(N+1). So done rises N+1 cycles after the cycle in which start was high.
- Throughput: a new start is accepted only in IDLE, so back-to-back operations take N+2 cycles each.
- start while busy (RUN or DONE) is ignored, not queued. Operand and mode changes during RUN have no effect.
- result is valid only from the done cycle onward. It holds stable, with carry_out and overflow, until the next accepted start; result clears on accept.
- result nibbles above idx during RUN read 0. Partial values are not guaranteed meaningful.
- done and busy are registered outputs, with no combinational path from start.
- Wrap-around: results are modulo 2^W, and carry_out captures the discarded bit.
- NIBBLES=1: RUN lasts one cycle, and the flags come from that single slice.
- Reset mid-RUN or in DONE: operation is aborted, no done pulse, all outputs read 0 in the next cycle.

Test Plan:
- Add, NIBBLES=4: a=0x1234, b=0x0FCD, m=0, start for one cycle -> busy high for 5 cycles; done pulse 5 cycles after start; result=0x2201, carry_out=0, overflow=0.
- Subtract: a=0x0005, b=0x0007, m=1 -> result=0xFFFE, carry_out=0 (borrow), overflow=0. Then a=0x8000, b=0x0001, m=1 -> result=0x7FFF, carry_out=1, overflow=1.
- Add boundaries:
  - a=0x7FFF, b=0x0001, m=0 -> result=0x8000, carry_out=0, overflow=1.
  - a=0xFFFF, b=0x0001, m=0 -> result=0x0000, carry_out=1, overflow=0.
- Busy rejection: start a=0x0001, b=0x0001, m=0. Then, in the 2nd cycle of RUN, assert start with a=0xAAAA, b=0x5555, m=1 and change the a/b inputs -> exactly one done; result=0x0002; block returns to IDLE with no second operation.
- Reset mid-operation: assert rst for one cycle in the 3rd RUN cycle -> next cycle busy=0, done=0, result=0, carry_out=0, overflow=0, and no done pulse follows. A subsequent start then completes normally with the correct result.
- Back-to-back: hold start high continuously with a=0x0010, b=0x0001 -> operations accepted every 6 cycles; each done shows result=0x0011; start is never accepted in DONE.
